// File: rtl/arb_n_af_service.sv
// arb_n_af_service: NUM_IN per-channel FIFOs with registered almost-full
// backpressure. The FIFOs are merged into a single registered output stage by
// either a fixed-priority arbiter or a round-robin arbiter. The block also
// keeps transfer and drop counters.
module arb_n_af_service #(
  parameter int NUM_IN     = 3,
  parameter int META_WIDTH = 32,
  parameter int DWIDTH     = META_WIDTH,
  parameter int DEPTH      = 512,
  parameter int FULL_LEVEL = 480,
  parameter int MODE       = 0
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [NUM_IN-1:0]          in_valid,
  input  logic [NUM_IN*DWIDTH-1:0]   in_data,
  output logic [NUM_IN-1:0]          in_almost_full,
  output logic                       out_valid,
  output logic [DWIDTH-1:0]          out_data,
  output logic [$clog2(NUM_IN)-1:0]  out_channel,
  input  logic                       out_ready,
  output logic [NUM_IN*32-1:0]       fill_level,
  output logic [31:0]                stats_out_meta,
  output logic [31:0]                stats_drop
);

  localparam int CHW = $clog2(NUM_IN);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(FULL_LEVEL);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  // Storage and state
  logic [DWIDTH-1:0] mem_q    [NUM_IN][DEPTH];
  logic [AW-1:0]     wr_ptr_q [NUM_IN];
  logic [AW-1:0]     rd_ptr_q [NUM_IN];
  logic [CW-1:0]     cnt_q    [NUM_IN];
  logic [CW-1:0]     cnt_d    [NUM_IN];
  logic [NUM_IN-1:0] af_q;
  logic [NUM_IN-1:0] af_d;
  logic              out_valid_q;
  logic [DWIDTH-1:0] out_data_q;
  logic [CHW-1:0]    out_channel_q;
  logic [CHW-1:0]    last_grant_q;
  logic [31:0]       stats_meta_q;
  logic [31:0]       stats_drop_q;

  // Combinational control
  logic              loadable_s;
  logic [NUM_IN-1:0] nonempty_s;
  logic              grant_any_s;
  logic [CHW-1:0]    grant_idx_s;
  logic [CHW-1:0]    cand_s;
  int                idx_s;
  logic [NUM_IN-1:0] pop_s;
  logic [NUM_IN-1:0] wr_s;
  logic [31:0]       drop_inc_s;
  logic [DWIDTH-1:0] head_s;

  assign loadable_s = !out_valid_q || out_ready;

  // Flag which channels hold at least one word.
  always_comb begin
    nonempty_s = {NUM_IN{1'b0}};
    for (int i = 0; i < NUM_IN; i++) begin
      nonempty_s[i] = (cnt_q[i] != {CW{1'b0}});
    end
  end

  // Arbiter: choose lowest index (MODE 0) or first after last_grant (MODE 1).
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = {CHW{1'b0}};
    cand_s      = {CHW{1'b0}};
    idx_s       = 0;
    if (MODE == 0) begin
      // Descending scan so that the lowest non-empty index is assigned last.
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        grant_idx_s = nonempty_s[i] ? CHW'(i) : grant_idx_s;
        grant_any_s = grant_any_s | nonempty_s[i];
      end
    end else begin
      // Descending distance so that the nearest channel after last_grant is assigned last.
      for (int k = NUM_IN; k >= 1; k--) begin
        idx_s       = int'(last_grant_q) + k;
        idx_s       = (idx_s >= NUM_IN) ? (idx_s - NUM_IN) : idx_s;
        cand_s      = CHW'(idx_s);
        grant_idx_s = nonempty_s[cand_s] ? cand_s : grant_idx_s;
        grant_any_s = grant_any_s | nonempty_s[cand_s];
      end
    end
  end

  // Head word of the granted channel; used only when a grant is issued.
  always_comb begin
    head_s = mem_q[grant_idx_s][rd_ptr_q[grant_idx_s]];
  end

  // Per-channel pop/accept decisions, next occupancy, and drop tally.
  always_comb begin
    pop_s      = {NUM_IN{1'b0}};
    wr_s       = {NUM_IN{1'b0}};
    af_d       = {NUM_IN{1'b0}};
    drop_inc_s = 32'd0;
    for (int i = 0; i < NUM_IN; i++) begin
      pop_s[i] = loadable_s && grant_any_s && (grant_idx_s == CHW'(i));
      // A full FIFO still accepts a write if it is popped in the same cycle.
      wr_s[i]  = in_valid[i] && ((cnt_q[i] != FULL_CNT) || pop_s[i]);
      drop_inc_s = drop_inc_s + ((in_valid[i] && !wr_s[i]) ? 32'd1 : 32'd0);
      case ({wr_s[i], pop_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + ONE_CNT;
        2'b01:   cnt_d[i] = cnt_q[i] - ONE_CNT;
        default: cnt_d[i] = cnt_q[i];
      endcase
      af_d[i] = (cnt_d[i] >= AF_CNT);
    end
  end

  // FIFO storage writes; contents are invalidated by pointer reset, not cleared.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < NUM_IN; i++) begin
      if (wr_s[i]) begin
        mem_q[i][wr_ptr_q[i]] <= in_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // Pointers, occupancy, almost-full flags, output register, and counters.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NUM_IN; i++) begin
        wr_ptr_q[i] <= {AW{1'b0}};
        rd_ptr_q[i] <= {AW{1'b0}};
        cnt_q[i]    <= {CW{1'b0}};
      end
      af_q          <= {NUM_IN{1'b0}};
      out_valid_q   <= 1'b0;
      out_data_q    <= {DWIDTH{1'b0}};
      out_channel_q <= {CHW{1'b0}};
      last_grant_q  <= CHW'(NUM_IN - 1);
      stats_meta_q  <= 32'd0;
      stats_drop_q  <= 32'd0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (wr_s[i]) begin
          wr_ptr_q[i] <= wr_ptr_q[i] + ONE_PTR;
        end
        if (pop_s[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + ONE_PTR;
        end
        cnt_q[i] <= cnt_d[i];
      end
      af_q <= af_d;
      if (loadable_s) begin
        if (grant_any_s) begin
          out_valid_q   <= 1'b1;
          out_data_q    <= head_s;
          out_channel_q <= grant_idx_s;
          last_grant_q  <= grant_idx_s;
        end else begin
          // Nothing to send: drop valid and keep the last data/channel.
          out_valid_q <= 1'b0;
        end
      end
      if (out_valid_q && out_ready) begin
        stats_meta_q <= stats_meta_q + 32'd1;
      end
      stats_drop_q <= stats_drop_q + drop_inc_s;
    end
  end

  // Zero-extend the per-channel occupancy onto the flat fill_level bus.
  always_comb begin
    fill_level = {(NUM_IN*32){1'b0}};
    for (int i = 0; i < NUM_IN; i++) begin
      fill_level[i*32 +: 32] = 32'(cnt_q[i]);
    end
  end

  assign in_almost_full = af_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_channel    = out_channel_q;
  assign stats_out_meta = stats_meta_q;
  assign stats_drop     = stats_drop_q;

endmodule

// File: tb/tb_arb_n_af_service.sv
// Scoreboard bench for arb_n_af_service. Two instances are used: one with
// fixed priority (u0) and one with round-robin (u1). Both have three channels,
// DEPTH 8 and FULL_LEVEL 6.
module tb_arb_n_af_service;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  iv0, iv1;
  logic [47:0] id0, id1;
  logic        ordy0, ordy1;
  logic [2:0]  af0, af1;
  logic        ov0, ov1;
  logic [15:0] od0, od1;
  logic [1:0]  oc0, oc1;
  logic [95:0] fl0, fl1;
  logic [31:0] sm0, sm1, sd0, sd1;

  int nchecks = 0;
  int npass   = 0;

  logic [17:0] exp0[$];
  logic [17:0] exp1[$];
  logic [17:0] e0, e1, held0, held1;
  logic        hold0 = 1'b0;
  logic        hold1 = 1'b0;

  always #5 clk = ~clk;

  arb_n_af_service #(.NUM_IN(3), .DWIDTH(16), .DEPTH(8), .FULL_LEVEL(6), .MODE(0)) u0 (
    .Clk(clk), .Rst(rst), .in_valid(iv0), .in_data(id0), .in_almost_full(af0),
    .out_valid(ov0), .out_data(od0), .out_channel(oc0), .out_ready(ordy0),
    .fill_level(fl0), .stats_out_meta(sm0), .stats_drop(sd0));

  arb_n_af_service #(.NUM_IN(3), .DWIDTH(16), .DEPTH(8), .FULL_LEVEL(6), .MODE(1)) u1 (
    .Clk(clk), .Rst(rst), .in_valid(iv1), .in_data(id1), .in_almost_full(af1),
    .out_valid(ov1), .out_data(od1), .out_channel(oc1), .out_ready(ordy1),
    .fill_level(fl1), .stats_out_meta(sm1), .stats_drop(sd1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nchecks++;
    if (act === req) npass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  function automatic logic [15:0] w(input int ch, input int k);
    return 16'((ch << 12) | k);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int d, input logic [2:0] v,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    if (d == 0) begin iv0 = v; id0 = {c, b, a}; end
    else        begin iv1 = v; id1 = {c, b, a}; end
  endtask

  task automatic push(input int d, input int ch, input int k);
    if (d == 0) exp0.push_back({2'(ch), w(ch, k)});
    else        exp1.push_back({2'(ch), w(ch, k)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic drain(input int d, input int budget);
    int n = 0;
    while (((d == 0) ? exp0.size() : exp1.size()) != 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk($sformatf("drain%0d_left", d), 64'((d == 0) ? exp0.size() : exp1.size()), 64'd0);
    tick(2);
  endtask

  function automatic logic [63:0] fsum(input logic [95:0] f);
    return 64'(f[31:0]) + 64'(f[63:32]) + 64'(f[95:64]);
  endfunction

  // Monitor u0: pop the expected word on each transfer; check stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      hold0 = 1'b0;
    end else begin
      if (hold0) chk("hold0", {ov0, oc0, od0}, {1'b1, held0});
      if (ov0 && ordy0) begin
        if (exp0.size() == 0) begin
          nchecks++;
          $display("FAIL unexpected0: actual ch%0d data %0h required no output", oc0, od0);
        end else begin
          e0 = exp0.pop_front();
          chk("out0", {oc0, od0}, e0);
        end
      end
      hold0 = ov0 && !ordy0;
      held0 = {oc0, od0};
    end
  end

  // Monitor u1: same discipline as u0.
  always @(negedge clk) begin
    if (rst) begin
      hold1 = 1'b0;
    end else begin
      if (hold1) chk("hold1", {ov1, oc1, od1}, {1'b1, held1});
      if (ov1 && ordy1) begin
        if (exp1.size() == 0) begin
          nchecks++;
          $display("FAIL unexpected1: actual ch%0d data %0h required no output", oc1, od1);
        end else begin
          e1 = exp1.pop_front();
          chk("out1", {oc1, od1}, e1);
        end
      end
      hold1 = ov1 && !ordy1;
      held1 = {oc1, od1};
    end
  end

  initial begin
    rst = 1'b1;
    iv0 = 3'd0; iv1 = 3'd0; id0 = 48'd0; id1 = 48'd0; ordy0 = 1'b0; ordy1 = 1'b0;
    tick(2);
    rst = 1'b0;

    // Reset state of both instances.
    chk("rst_out0", {ov0, oc0, od0}, 64'd0);
    chk("rst_out1", {ov1, oc1, od1}, 64'd0);
    chk("rst_fill0", fsum(fl0), 64'd0);
    chk("rst_fill1", fsum(fl1), 64'd0);
    chk("rst_stats0", {sm0, sd0}, 64'd0);
    chk("rst_stats1", {sm1, sd1}, 64'd0);
    chk("rst_af0", af0, 64'd0);
    chk("rst_af1", af1, 64'd0);

    // Simultaneous writes to ch2 and ch0 on the priority instance; ch0 wins, two-cycle latency.
    ordy0 = 1'b1;
    set_in(0, 3'b101, w(0, 0), 16'd0, w(2, 0));
    push(0, 0, 0);
    push(0, 2, 0);
    tick(1);
    set_in(0, 3'b000, 16'd0, 16'd0, 16'd0);
    chk("lat_nobypass", ov0, 64'd0);
    tick(1);
    chk("lat_first", {ov0, oc0}, {1'b1, 2'd0});
    tick(1);
    chk("lat_second", {ov0, oc0}, {1'b1, 2'd2});
    tick(1);
    chk("lat_empty", ov0, 64'd0);
    drain(0, 20);

    // Fixed priority versus round-robin on identical stimulus.
    do_reset();
    for (int d = 0; d < 2; d++) begin
      if (d == 0) ordy0 = 1'b1; else ordy1 = 1'b1;
      push(d, 0, 1);
      if (d == 0) begin push(d, 0, 2); push(d, 1, 1); end
      else        begin push(d, 1, 1); push(d, 0, 2); end
      set_in(d, 3'b011, w(0, 1), w(1, 1), 16'd0);
      tick(1);
      set_in(d, 3'b001, w(0, 2), 16'd0, 16'd0);
      tick(1);
      set_in(d, 3'b000, 16'd0, 16'd0, 16'd0);
      drain(d, 30);
    end

    // Round-robin over three preloaded channels: twelve transfers in 0,1,2 order.
    do_reset();
    ordy1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_in(1, 3'b111, w(0, k), w(1, k), w(2, k));
      tick(1);
    end
    set_in(1, 3'b000, 16'd0, 16'd0, 16'd0);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) push(1, c, k);
    end
    tick(1);
    chk("rr_af_low", af1, 64'd0);
    chk("rr_fill_pre", fsum(fl1), 64'd11);
    ordy1 = 1'b1;
    drain(1, 60);
    chk("rr_meta", sm1, 64'd12);
    chk("rr_fill_post", fsum(fl1), 64'd0);

    // Mid-operation reset with five words buffered and the output register loaded.
    ordy1 = 1'b0;
    set_in(1, 3'b111, w(0, 4), w(1, 4), w(2, 4));
    tick(1);
    set_in(1, 3'b111, w(0, 5), w(1, 5), w(2, 5));
    tick(1);
    set_in(1, 3'b000, 16'd0, 16'd0, 16'd0);
    chk("pre_rst_state", {ov1, fsum(fl1)[7:0]}, {1'b1, 8'd5});
    rst = 1'b1;
    ordy1 = 1'b1;
    set_in(1, 3'b111, w(0, 7), w(1, 7), w(2, 7));
    tick(1);
    rst = 1'b0;
    set_in(1, 3'b000, 16'd0, 16'd0, 16'd0);
    chk("midrst_valid", ov1, 64'd0);
    chk("midrst_fill", fsum(fl1), 64'd0);
    chk("midrst_stats", {sm1, sd1}, 64'd0);
    tick(10);
    chk("midrst_no_stale", {ov1, sm1}, 64'd0);

    // Fill ch1 behind a stalled output register; check almost-full timing and drops.
    do_reset();
    ordy0 = 1'b0;
    set_in(0, 3'b001, w(0, 9), 16'd0, 16'd0);
    push(0, 0, 9);
    tick(1);
    set_in(0, 3'b000, 16'd0, 16'd0, 16'd0);
    tick(1);
    chk("af_stalled_valid", {ov0, oc0}, {1'b1, 2'd0});
    for (int k = 0; k < 10; k++) begin
      set_in(0, 3'b010, 16'd0, w(1, k), 16'd0);
      if (k < 8) push(0, 1, k);
      tick(1);
      if (k == 4) chk("af_after5", af0, 64'd0);
      if (k == 5) chk("af_after6", af0, 64'b010);
    end
    set_in(0, 3'b000, 16'd0, 16'd0, 16'd0);
    chk("full_fill", fl0[63:32], 64'd8);
    chk("full_drops", sd0, 64'd2);

    // Write and pop on the full channel in one cycle: occupancy stays 8 and no new drop.
    ordy0 = 1'b1;
    set_in(0, 3'b010, 16'd0, w(1, 10), 16'd0);
    push(0, 1, 10);
    tick(1);
    set_in(0, 3'b000, 16'd0, 16'd0, 16'd0);
    chk("wrpop_fill", fl0[63:32], 64'd8);
    chk("wrpop_drops", sd0, 64'd2);
    drain(0, 60);
    chk("wrpop_meta", sm0, 64'd10);
    chk("wrpop_fill_end", fsum(fl0), 64'd0);
    chk("wrpop_af_end", af0, 64'd0);

    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

endmodule

// File: doc/arb_n_af_service.md
ARB_N_AF_SERVICE -- requirements
Module: arb_n_af_service

Interface
REQ-001 Parameter NUM_IN, default 3: number of input channels; legal range 2..8.
REQ-002 Parameter DWIDTH, default META_WIDTH: data width per channel.
REQ-003 Parameter DEPTH, default 512: per-channel FIFO depth; power of 2.
REQ-004 Parameter FULL_LEVEL, default 480: almost-full threshold; 1 <= FULL_LEVEL <= DEPTH.
REQ-005 Parameter MODE, default 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
REQ-006 Clk  input  1  single clock; all logic on its rising edge.
REQ-007 Rst  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  NUM_IN  per-channel write strobe.
REQ-009 in_data  input  NUM_IN*DWIDTH  channel i occupies bits [i*DWIDTH +: DWIDTH].
REQ-010 in_almost_full  output  NUM_IN  per-channel backpressure to producer.
REQ-011 out_valid  output  1  output register holds a word.
REQ-012 out_data  output  DWIDTH  word presented downstream.
REQ-013 out_channel  output  $clog2(NUM_IN)  source channel index of out_data.
REQ-014 out_ready  input  1  downstream accepts the word when high together with out_valid.
REQ-015 fill_level  output  NUM_IN*32  per-channel occupancy, zero-extended.
REQ-016 stats_out_meta  output  32  count of completed output transfers.
REQ-017 stats_drop  output  32  count of writes dropped on full FIFOs, all channels summed.

Function
REQ-018 Each channel SHALL own a FIFO of DEPTH entries with an occupancy count of width $clog2(DEPTH+1) and read/write pointers that wrap modulo DEPTH.
REQ-019 in_almost_full[i] SHALL be registered and equal (occupancy_i >= FULL_LEVEL) as of the previous edge.
REQ-020 A write with in_valid[i]=1 SHALL be accepted unless occupancy_i == DEPTH with no pop of channel i in the same cycle; a rejected write SHALL be discarded and SHALL increment stats_drop by 1 per channel dropped that cycle.
REQ-021 Simultaneous write and pop on a full FIFO SHALL both complete, leaving occupancy unchanged at DEPTH.
REQ-022 The output register SHALL be loadable when out_valid==0 or (out_valid && out_ready).
REQ-023 When loadable and at least one FIFO is non-empty, exactly one channel SHALL be granted and popped, and its head word and index SHALL load out_data/out_channel, with out_valid=1 on the next cycle.
REQ-024 A word written at the edge ending cycle t SHALL be grantable in cycle t+1 and appear on out_valid no earlier than cycle t+2; there is no FIFO bypass.
REQ-025 MODE 0: the grant SHALL go to the lowest-index non-empty channel.
REQ-026 MODE 1: the grant SHALL go to the first non-empty channel after last_grant, searching cyclically; last_grant updates only on a grant.
REQ-027 When not loadable, no pop SHALL occur, and out_valid, out_data and out_channel SHALL hold stable.
REQ-028 When loadable and all FIFOs are empty, out_valid SHALL go to 0; out_data and out_channel SHALL hold their last values.
REQ-029 Sustained throughput SHALL be one word per cycle while out_ready=1 and any FIFO is non-empty.
REQ-030 Per-channel word order SHALL be preserved; no word SHALL be duplicated or lost except drops counted per REQ-020.
REQ-031 stats_out_meta SHALL increment on each cycle with out_valid && out_ready; both stats counters wrap modulo 2^32.

Reset
REQ-032 While Rst=1: all occupancies and pointers 0; in_almost_full 0; out_valid 0; out_data 0; out_channel 0; fill_level 0; stats 0; last_grant = NUM_IN-1, so channel 0 is searched first.
REQ-033 in_valid and out_ready SHALL be ignored while Rst=1.
REQ-034 Reset asserted mid-operation SHALL discard all buffered words and the output register content on the next edge.

Verification
REQ-035 MODE 0, NUM_IN=3, out_ready=1: write A to ch2 and B to ch0 in the same cycle -> B (out_channel 0) appears two cycles later, A (channel 2) on the following cycle.
REQ-036 MODE 1, all three channels each preloaded with 4 words, out_ready=1 -> out_channel sequence 0,1,2,0,1,2,... for 12 transfers; stats_out_meta = 12.
REQ-037 DEPTH=8, FULL_LEVEL=6, out_ready=0: write 10 words to ch1 -> in_almost_full[1]=1 the cycle after the 6th write; fill_level ch1 = 8; stats_drop = 2.
REQ-038 Full ch0 (DEPTH=8), out_ready=1, write and pop in the same cycle -> occupancy stays 8 and stats_drop stays 0.
REQ-039 out_ready toggled randomly over 1000 random writes on all channels -> per-channel order preserved; out_data stable while out_valid && !out_ready; counts reconcile: writes = outputs + drops.
REQ-040 Rst pulsed for 1 cycle with 5 words buffered and out_valid=1 -> the next cycle shows out_valid=0, fill_level all 0, stats 0, and no stale word emerges afterwards.
